// File: rtl/uart_rcv_if.sv
// UART receiver bundle: serial line in, recovered byte and status strobes out.
interface uart_rcv_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_done;
    logic                 rx_err;
    logic                 rx_busy;

    modport slave (
        input  rx,
        output dout, rx_done, rx_err, rx_busy
    );

    modport master (
        output rx,
        input  dout, rx_done, rx_err, rx_busy
    );
endinterface

// File: rtl/uart_rcv.sv
// UART 8N1 receiver: two-flop synchroniser, mid-bit start check,
// centre sampling of data bits, stop-bit check with break hold-off.
module uart_rcv #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    uart_rcv_if.slave    bus
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BRK
    } state_t;

    state_t               state, state_n;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] dout;
    logic                 done, err;
    logic                 cnt_half, cnt_last, idx_last;
    logic                 shift_en, done_set, err_set, busy;

    assign rx_s     = sync[1];
    assign cnt_half = (cnt == CW'(HALF - 1));
    assign cnt_last = (cnt == CW'(CPB - 1));
    assign idx_last = (idx == IW'(DATA_BITS - 1));

    // Idle-high reset value keeps the line from looking like a start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], bus.rx};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (!rx_s) state_n = START;
            START: if (cnt_half) state_n = rx_s ? IDLE : DATA;
            DATA:  if (cnt_last && idx_last) state_n = STOP;
            STOP:  if (cnt_last) state_n = rx_s ? IDLE : BRK;
            BRK:   if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        shift_en = (state == DATA) && cnt_last;
        done_set = (state == STOP) && cnt_last && rx_s;
        err_set  = (state == STOP) && cnt_last && !rx_s;
        shift_n  = shift >> 1;
        shift_n[DATA_BITS-1] = rx_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            dout  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (state_n != state || shift_en)
                cnt <= '0;
            else if (state != IDLE && state != BRK)
                cnt <= cnt + 1'b1;
            if (state == START)
                idx <= '0;
            else if (shift_en && !idx_last)
                idx <= idx + 1'b1;
            if (shift_en)
                shift <= shift_n;
            if (done_set)
                dout <= shift;
            done <= done_set;
            err  <= err_set;
        end
    end

    assign bus.dout    = dout;
    assign bus.rx_done = done;
    assign bus.rx_err  = err;
    assign bus.rx_busy = busy;
endmodule

// File: tb/tb_uart_rcv.sv
// Self-checking bench for uart_rcv at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rcv;
    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         gap;
        logic [7:0] exp_dout;
        int         exp_done;
        int         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    logic [7:0] model_dout = 8'h00;
    logic [7:0] prev_dout = 8'h00;
    logic       prev_pulse = 1'b0;

    uart_rcv_if #(.DATA_BITS(8)) bus ();

    uart_rcv #(
        .CLK_FREQ (50_000_000),
        .BAUD     (3_125_000),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe exclusivity, single-cycle width, dout only moves with rx_done
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rx_done) done_cnt++;
            if (bus.rx_err) err_cnt++;
            if (bus.rx_done || bus.rx_err) begin
                chk("strobe_excl", 32'(bus.rx_done & bus.rx_err), 0);
                chk("strobe_width", 32'(prev_pulse), 0);
            end
            if (bus.dout !== prev_dout)
                chk("dout_with_done", 32'(bus.rx_done), 1);
        end
        prev_pulse = bus.rx_done | bus.rx_err;
        prev_dout  = bus.dout;
    end

    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop);
        send_bits(d);
        hold(stop, CPB);
    endtask

    // Drives one frame, updates the reference, compares strobe counts and dout
    task automatic run_frame(input string name, input logic [7:0] d,
                             input bit stop, input int gap,
                             output int dd, output int de);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(d, stop);
        hold(1'b1, gap);
        if (stop) model_dout = d;
        dd = done_cnt - d0;
        de = err_cnt - e0;
        chk({name, "_done"}, 32'(dd), stop ? 1 : 0);
        chk({name, "_err"}, 32'(de), stop ? 0 : 1);
        chk({name, "_dout"}, 32'(bus.dout), 32'(model_dout));
        if (gap >= 4) chk({name, "_idle"}, 32'(bus.rx_busy), 0);
    endtask

    initial begin
        vec_t vecs[5];
        int dd, de, d0, e0, lat, t0;
        bit saw_busy, got;
        logic [7:0] keep;

        vecs[0] = '{8'hAA, 1'b1, 4, 8'hAA, 1, 0};
        vecs[1] = '{8'h55, 1'b1, 0, 8'h55, 1, 0};
        vecs[2] = '{8'h0F, 1'b1, 4, 8'h0F, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 4, 8'h0F, 0, 1};
        vecs[4] = '{8'h81, 1'b1, 4, 8'h81, 1, 0};

        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_done", 32'(bus.rx_done), 0);
        chk("rst_err", 32'(bus.rx_err), 0);
        chk("rst_busy", 32'(bus.rx_busy), 0);
        rst = 1'b1;
        hold(1'b1, 8);

        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop,
                      vecs[i].gap, dd, de);
            chk($sformatf("vec%0d_tdout", i), 32'(bus.dout),
                32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_tdone", i), 32'(dd), 32'(vecs[i].exp_done));
            chk($sformatf("vec%0d_terr", i), 32'(de), 32'(vecs[i].exp_err));
        end

        // Short low glitch enters START then falls back to IDLE
        d0 = done_cnt; e0 = err_cnt; keep = bus.dout; saw_busy = 1'b0;
        bus.rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            saw_busy |= bus.rx_busy;
        end
        bus.rx = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            saw_busy |= bus.rx_busy;
        end
        chk("glitch_start", 32'(saw_busy), 1);
        chk("glitch_idle", 32'(bus.rx_busy), 0);
        chk("glitch_done", 32'(done_cnt - d0), 0);
        chk("glitch_err", 32'(err_cnt - e0), 0);
        chk("glitch_dout", 32'(bus.dout), 32'(keep));

        // Framing error with the line held low: waits in BRK until released
        d0 = done_cnt; e0 = err_cnt; keep = bus.dout;
        send_bits(8'h3C);
        hold(1'b0, 40);
        chk("brk_err", 32'(err_cnt - e0), 1);
        chk("brk_busy", 32'(bus.rx_busy), 1);
        hold(1'b1, 6);
        chk("brk_exit", 32'(bus.rx_busy), 0);
        chk("brk_done", 32'(done_cnt - d0), 0);
        chk("brk_dout", 32'(bus.dout), 32'(keep));
        run_frame("after_brk", 8'h81, 1'b1, 4, dd, de);

        // Reset mid data bit 3 aborts everything immediately
        d0 = done_cnt; e0 = err_cnt;
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b0, CPB / 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(bus.dout), 0);
        chk("mid_rst_done", 32'(bus.rx_done), 0);
        chk("mid_rst_err", 32'(bus.rx_err), 0);
        chk("mid_rst_busy", 32'(bus.rx_busy), 0);
        model_dout = 8'h00;
        hold(1'b1, 4);
        rst = 1'b1;
        hold(1'b1, 6);
        chk("mid_rst_nostrobe", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
        run_frame("post_rst", 8'hC3, 1'b1, 4, dd, de);

        // Serial-transmitter style frame with decision latency window
        d0 = done_cnt; got = 1'b0; lat = 0;
        fork
            send_frame(8'hAA, 1'b1);
            begin
                t0 = cyc;
                for (int i = 0; i < 300 && !got; i++) begin
                    @(negedge clk);
                    if (bus.rx_done) begin
                        got = 1'b1;
                        lat = cyc - t0;
                    end
                end
            end
        join
        hold(1'b1, 4);
        model_dout = 8'hAA;
        chk("loop_seen", 32'(got), 1);
        chk("loop_lat_ok", 32'(lat >= 153 && lat <= 156), 1);
        chk("loop_done", 32'(done_cnt - d0), 1);
        chk("loop_dout", 32'(bus.dout), 32'hAA);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            bit s;
            int g;
            d = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            g = s ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 8));
            run_frame($sformatf("rnd%0d", i), d, s, g, dd, de);
        end
        hold(1'b1, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
